// File: rtl/lut_ram_arbiter_if.sv
// Request/response and RAM-port bundle between requesters, lut_ram_arbiter and lut_ram.
// The slave modport is the arbiter's view; the master modport is the requester/RAM-side view.
interface lut_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_we;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wdata;
  logic [1:0]                 req_ready;
  logic [1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       ram_wr_en;
  logic [ADDR_WIDTH-1:0]      ram_wr_addr;
  logic [DATA_WIDTH-1:0]      ram_wr_data;
  logic [ADDR_WIDTH-1:0]      ram_rd_addr;
  logic [DATA_WIDTH-1:0]      ram_rd_data;
  logic                       busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_rd_data,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_rd_data,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr, busy
  );
endinterface

// File: rtl/lut_ram_arbiter.sv
// Round-robin two-requester arbiter in front of an async-read lut_ram, with registered read responses.
// Define LUT_RAM_ARB_CLEAR_EN to add a post-reset sweep that zeroes every RAM entry.
module lut_ram_arbiter #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  lut_ram_arbiter_if.slave bus
);

  localparam logic [0:0] ST_ARB   = 1'b1;
`ifdef LUT_RAM_ARB_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RESET = ST_CLEAR;
`else
  localparam logic [0:0] ST_RESET = ST_ARB;
`endif

  logic [0:0]            r_state;
  logic                  r_ptr;
  logic [1:0]            r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
`ifdef LUT_RAM_ARB_CLEAR_EN
  logic [ADDR_WIDTH-1:0] r_clr_addr;
`endif

  logic [1:0] w_grant;
  logic       w_gsel;
  logic       w_hs;
  logic       w_rd_hs;

  // Grant is gated off during reset so no handshake can complete on a reset edge.
  always_comb begin
    w_grant = 2'b00;
    if (!rst && r_state == ST_ARB) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_gsel  = w_grant[1];
  assign w_hs    = |w_grant;
  assign w_rd_hs = w_hs && !bus.req_we[w_gsel];

  always_comb begin
    bus.req_ready   = w_grant;
    bus.ram_wr_en   = w_hs && bus.req_we[w_gsel];
    bus.ram_wr_addr = bus.req_addr[w_gsel];
    bus.ram_wr_data = bus.req_wdata[w_gsel];
    bus.ram_rd_addr = bus.req_addr[w_gsel];
    bus.busy        = 1'b0;
`ifdef LUT_RAM_ARB_CLEAR_EN
    if (r_state == ST_CLEAR) begin
      bus.ram_wr_en   = !rst;
      bus.ram_wr_addr = r_clr_addr;
      bus.ram_wr_data = '0;
      bus.busy        = 1'b1;
    end
`endif
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_ptr       <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= '0;
`ifdef LUT_RAM_ARB_CLEAR_EN
      r_clr_addr  <= '0;
`endif
    end else begin
      r_rsp_valid <= 2'b00;
      if (r_state == ST_ARB) begin
        if (w_hs) begin
          r_ptr <= ~w_gsel;
        end
        if (w_rd_hs) begin
          r_rsp_valid <= w_grant;
          r_rsp_rdata <= bus.ram_rd_data;
        end
      end
`ifdef LUT_RAM_ARB_CLEAR_EN
      // Sweep stops on the last address instead of wrapping back to zero.
      else begin
        if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
          r_state <= ST_ARB;
        end else begin
          r_clr_addr <= r_clr_addr + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_lut_ram_arbiter.sv
// Self-checking bench for lut_ram_arbiter: behavioural lut_ram, round-robin model and response scoreboard.
module tb_lut_ram_arbiter;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [1:0]    mask;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lut_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lut_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural lut_ram: synchronous write, combinational read.
  logic [DW-1:0] ramMem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wr_en) ramMem[bus.ram_wr_addr] <= bus.ram_wr_data;
  end
  assign bus.ram_rd_data = ramMem[bus.ram_rd_addr];

  logic [DW-1:0] refMem [DEPTH];
  logic          modelPtr;
  logic [DW-1:0] lastRdata;
  rsp_t          expQ[$];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One bus cycle: drive after a posedge, check at the negedge, then advance the model.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    logic [1:0]    g;
    logic          s;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    rsp_t          e;
    bus.req_valid    = valid;
    bus.req_we       = we;
    bus.req_addr[0]  = a0;
    bus.req_addr[1]  = a1;
    bus.req_wdata[0] = d0;
    bus.req_wdata[1] = d1;
    @(negedge clk);
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("rsp_valid", {30'd0, bus.rsp_valid}, {30'd0, e.mask});
      checkOutput("rsp_rdata", bus.rsp_rdata, e.data);
      lastRdata = e.data;
    end else begin
      checkOutput("rsp_idle", {30'd0, bus.rsp_valid}, 32'd0);
      checkOutput("rsp_hold", bus.rsp_rdata, lastRdata);
    end
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = modelPtr ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    checkOutput("req_ready", {30'd0, bus.req_ready}, {30'd0, g});
    checkOutput("busy", {31'd0, bus.busy}, 32'd0);
    if (g != 2'b00) begin
      s        = g[1];
      ga       = s ? a1 : a0;
      gd       = s ? d1 : d0;
      modelPtr = ~s;
      if (we[s]) begin
        checkOutput("wr_en", {31'd0, bus.ram_wr_en}, 32'd1);
        checkOutput("wr_addr", {25'd0, bus.ram_wr_addr}, {25'd0, ga});
        checkOutput("wr_data", bus.ram_wr_data, gd);
        refMem[ga] = gd;
      end else begin
        checkOutput("rd_wr_en", {31'd0, bus.ram_wr_en}, 32'd0);
        checkOutput("rd_addr", {25'd0, bus.ram_rd_addr}, {25'd0, ga});
        e.mask = g;
        e.data = refMem[ga];
        expQ.push_back(e);
      end
    end else begin
      checkOutput("idle_wr_en", {31'd0, bus.ram_wr_en}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  // One reset cycle with requests pending, then the clear sweep when it is built in.
  task automatic doReset(input logic [1:0] valid);
    rst           = 1'b1;
    bus.req_valid = valid;
    bus.req_we    = 2'b00;
    @(negedge clk);
    checkOutput("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    checkOutput("rst_wr_en", {31'd0, bus.ram_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    rst       = 1'b0;
    expQ.delete();
    modelPtr  = 1'b0;
    lastRdata = '0;
`ifdef LUT_RAM_ARB_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      bus.req_valid = 2'b11;
      @(negedge clk);
      checkOutput("clr_busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("clr_ready", {30'd0, bus.req_ready}, 32'd0);
      checkOutput("clr_wr_en", {31'd0, bus.ram_wr_en}, 32'd1);
      checkOutput("clr_wr_addr", {25'd0, bus.ram_wr_addr}, i);
      checkOutput("clr_wr_data", bus.ram_wr_data, 32'd0);
      refMem[i] = '0;
      @(posedge clk);
      #1;
    end
`endif
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_valid    = 2'b00;
    bus.req_we       = 2'b00;
    bus.req_addr[0]  = '0;
    bus.req_addr[1]  = '0;
    bus.req_wdata[0] = '0;
    bus.req_wdata[1] = '0;
    modelPtr         = 1'b0;
    lastRdata        = '0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;

    doReset(2'b11);

`ifdef LUT_RAM_ARB_CLEAR_EN
    applyStimulus(2'b01, 2'b00, 7'd0, 7'd0, '0, '0);
    applyStimulus(2'b10, 2'b00, 7'd0, 7'd63, '0, '0);
    applyStimulus(2'b01, 2'b00, 7'd127, 7'd0, '0, '0);
    idleCycle();
`endif

    // Single requester: write then read back the next cycle.
    applyStimulus(2'b01, 2'b01, 7'd10, 7'd0, 32'hDEADBEEF, '0);
    applyStimulus(2'b01, 2'b00, 7'd10, 7'd0, '0, '0);
    idleCycle();

    // Preload, then contention between two continuous readers.
    applyStimulus(2'b01, 2'b01, 7'd5, 7'd0, 32'h5, '0);
    applyStimulus(2'b10, 2'b10, 7'd0, 7'd6, '0, 32'h6);
    for (int i = 0; i < 6; i++) applyStimulus(2'b11, 2'b00, 7'd5, 7'd6, '0, '0);
    idleCycle();

    // Fairness after idle: req1 alone, then both.
    applyStimulus(2'b10, 2'b00, 7'd5, 7'd6, '0, '0);
    idleCycle();
    applyStimulus(2'b11, 2'b00, 7'd5, 7'd6, '0, '0);
    applyStimulus(2'b11, 2'b00, 7'd5, 7'd6, '0, '0);
    idleCycle();

    // Write by req0 while req1 waits to read the same address.
    applyStimulus(2'b11, 2'b01, 7'd90, 7'd90, 32'h1234, '0);
    applyStimulus(2'b11, 2'b00, 7'd90, 7'd90, '0, '0);
    idleCycle();

    // Randomised mix over a preloaded window.
    for (int i = 0; i < 16; i++) applyStimulus(2'b01, 2'b01, i[AW-1:0], 7'd0, $urandom, '0);
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 15), $urandom_range(0, 15), $urandom, $urandom);
    end
    idleCycle();

    // Reset in the cycle after a read handshake drops the response.
    applyStimulus(2'b01, 2'b00, 7'd10, 7'd0, '0, '0);
    doReset(2'b01);
    applyStimulus(2'b11, 2'b11, 7'd20, 7'd21, 32'hA0A0, 32'hB1B1);
    applyStimulus(2'b11, 2'b00, 7'd20, 7'd21, '0, '0);
    applyStimulus(2'b11, 2'b00, 7'd20, 7'd21, '0, '0);
    applyStimulus(2'b11, 2'b00, 7'd20, 7'd21, '0, '0);
    idleCycle();
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
